fixed_point_divider: RTL

Iterative restoring divider for unsigned Q(WIDTH−FBITS).FBITS fixed-point operands, the inverse of the fixed-point unit's multiplier path. It sits beside the fixed-point unit in the execute stage and has its own start/ready handshake. Each run computes floor((operand_1 << FBITS) / operand_2), one quotient bit per clock, and flags divide-by-zero and quotient overflow.

---
 rtl/fxp_pkg.sv | 18 +
 rtl/fixed_point_divider_if.sv | 27 ++
 rtl/fxp_div_step.sv | 22 ++
 rtl/fixed_point_divider.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: default operand format, divider FSM states and
// the quotient-bit count used by the divider.
package fxp_pkg;

  localparam int FXP_WIDTH = 32;
  localparam int FXP_FBITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  function automatic int div_iter(input int width, input int fbits);
    return width + fbits;
  endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Start/ready handshake and operand/result bus of the fixed-point divider.
interface fixed_point_divider_if
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             busy;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, operand_1, operand_2,
    input  result, ready, busy, div_by_zero, overflow
  );

  modport slave (
    input  start, operand_1, operand_2,
    output result, ready, busy, div_by_zero, overflow
  );

endinterface

// File: rtl/fxp_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module fxp_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   remainder,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_remainder,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The remainder always stays below the divisor, so its top bit is zero and drops out here.
  assign shifted        = (WIDTH + 1)'({remainder, dividend_bit});
  assign trial          = shifted - {1'b0, divisor};
  assign quotient_bit   = ~trial[WIDTH];
  assign next_remainder = quotient_bit ? trial : shifted;

endmodule

// File: rtl/fixed_point_divider.sv
// Iterative restoring divider computing floor((operand_1 << FBITS) / operand_2), one bit per clock.
// Define FXP_DIV_SIGNED_EN for two's-complement operands (one extra cycle for the sign fix-up).
module fixed_point_divider
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_WIDTH,
  parameter int FBITS = FXP_FBITS
) (
  input logic                  clk,
  input logic                  reset,
  fixed_point_divider_if.slave bus
);

  localparam int ITER = div_iter(WIDTH, FBITS);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(ITER - 1);

  div_state_t       state, state_next;
  logic [ITER-1:0]  dividend, quotient, quotient_next;
  logic [WIDTH:0]   remainder, remainder_next;
  logic [WIDTH-1:0] divisor, load_dividend, load_divisor;
  logic [CW-1:0]    count;
  logic             quotient_bit, pending, fixup_cycle;
  logic             accept, step, calc_last;
  logic             publish, pub_dbz, pub_ovf;
  logic [WIDTH-1:0] pub_result, result_q;
  logic             ready_q, busy_q, dbz_q, ovf_q;

  fxp_div_step #(.WIDTH(WIDTH)) u_step (
    .remainder     (remainder),
    .dividend_bit  (dividend[ITER-1]),
    .divisor       (divisor),
    .next_remainder(remainder_next),
    .quotient_bit  (quotient_bit)
  );

  assign quotient_next = (quotient << 1) | ITER'(quotient_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A pending DONE cycle (divide-by-zero or sign fix-up) publishes before returning to IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    calc_last  = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept     = 1'b1;
        state_next = (bus.operand_2 == '0) ? DONE : CALC;
      end
      CALC: begin
        step = 1'b1;
        if (count == LAST_STEP) begin
          calc_last  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: if (!pending) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef FXP_DIV_SIGNED_EN
  localparam logic [ITER-1:0] POS_LIMIT = {{(ITER - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [ITER-1:0] NEG_LIMIT = POS_LIMIT + ITER'(1);

  logic neg_result, neg_dividend;

  assign load_dividend = bus.operand_1[WIDTH-1] ? (~bus.operand_1 + WIDTH'(1)) : bus.operand_1;
  assign load_divisor  = bus.operand_2[WIDTH-1] ? (~bus.operand_2 + WIDTH'(1)) : bus.operand_2;
  assign fixup_cycle   = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_result   <= 1'b0;
      neg_dividend <= 1'b0;
    end else if (accept) begin
      neg_result   <= bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1];
      neg_dividend <= bus.operand_1[WIDTH-1];
    end
  end

  always_comb begin
    publish    = (state == DONE) && pending;
    pub_dbz    = (divisor == '0);
    pub_ovf    = 1'b0;
    pub_result = neg_result ? (~quotient[WIDTH-1:0] + WIDTH'(1)) : quotient[WIDTH-1:0];
    if (pub_dbz) begin
      pub_result = neg_dividend ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end else begin
      pub_ovf = quotient > (neg_result ? NEG_LIMIT : POS_LIMIT);
    end
  end
`else
  assign load_dividend = bus.operand_1;
  assign load_divisor  = bus.operand_2;
  assign fixup_cycle   = 1'b0;

  // Normal results publish with the last step; only divide-by-zero publishes from DONE.
  always_comb begin
    publish    = calc_last || ((state == DONE) && pending);
    pub_dbz    = (state == DONE);
    pub_ovf    = 1'b0;
    pub_result = '1;
    if (!pub_dbz) begin
      pub_result = quotient_next[WIDTH-1:0];
      pub_ovf    = |quotient_next[ITER-1:WIDTH];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend  <= '0;
      quotient  <= '0;
      remainder <= '0;
      divisor   <= '0;
      count     <= '0;
      pending   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ready_q <= publish;
      if (accept) begin
        dividend  <= {load_dividend, {FBITS{1'b0}}};
        divisor   <= load_divisor;
        remainder <= '0;
        quotient  <= '0;
        count     <= '0;
        busy_q    <= 1'b1;
        pending   <= (bus.operand_2 == '0);
      end
      if (step) begin
        dividend  <= dividend << 1;
        remainder <= remainder_next;
        quotient  <= quotient_next;
        count     <= count + CW'(1);
        if (calc_last) pending <= fixup_cycle;
      end
      if (publish) begin
        result_q <= pub_result;
        dbz_q    <= pub_dbz;
        ovf_q    <= pub_ovf;
        pending  <= 1'b0;
      end
      if ((state == DONE) && !pending) busy_q <= 1'b0;
    end
  end

  assign bus.result      = result_q;
  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
